// File: rtl/line_burst_mem_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg
// Shared types and constants for the line-granular burst backing memory:
// FSM state encoding, latched operation type, word width and the line-size
// helper used to derive LINE_SIZE from LINE_ADDR_LEN.
// -----------------------------------------------------------------------------
package mem_pkg;

    localparam int WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST,
        DONE
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    // Words per line for a given log2 line size.
    function automatic int line_size(input int line_addr_len);
        return 1 << line_addr_len;
    endfunction

endpackage

// File: rtl/line_burst_mem_if.sv
// -----------------------------------------------------------------------------
// line_burst_mem_if
// Line-wide request/grant bus between the data cache (master) and the
// backing memory (slave).
//   gnt      slave->master  one-cycle completion pulse
//   addr     master->slave  line address, sampled at acceptance
//   rd_req   master->slave  line read request, level, held until gnt
//   wr_req   master->slave  line write request, level, held until gnt
//   rd_line  slave->master  line read data, valid in the gnt cycle
//   wr_line  master->slave  line write data, sampled at acceptance
// -----------------------------------------------------------------------------
interface line_burst_mem_if #(
    parameter int ADDR_LEN  = 9,
    parameter int LINE_SIZE = 8
);
    import mem_pkg::*;

    logic                                gnt;
    logic [ADDR_LEN-1:0]                 addr;
    logic                                rd_req;
    logic                                wr_req;
    logic [LINE_SIZE-1:0][WORD_W-1:0]    rd_line;
    logic [LINE_SIZE-1:0][WORD_W-1:0]    wr_line;

    modport master (
        input  gnt, rd_line,
        output addr, rd_req, wr_req, wr_line
    );

    modport slave (
        output gnt, rd_line,
        input  addr, rd_req, wr_req, wr_line
    );

endinterface

// File: rtl/line_burst_mem_word_ram.sv
// -----------------------------------------------------------------------------
// mem_word_ram
// Single-port word RAM backing the line memory. Synchronous write,
// combinational read. Power-up content is word[w] = w.
//   clk    clock
//   we     write enable
//   addr   word address {line_addr, word_idx}
//   wdata  write data
//   rdata  read data for addr (combinational)
// -----------------------------------------------------------------------------
module mem_word_ram
    import mem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [WORD_W-1:0] wdata,
    output logic [WORD_W-1:0] rdata
);

    localparam int DEPTH = 1 << AW;

    typedef logic [WORD_W-1:0] mem_t [DEPTH];

    function automatic mem_t init_pattern();
        mem_t m;
        for (int w = 0; w < DEPTH; w++) begin
            m[w] = WORD_W'(w);
        end
        return m;
    endfunction

    mem_t mem = init_pattern();

    // NOTE: storage has no reset; a reset port would turn the array into
    // thousands of flops and would also wipe data a reset must preserve.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/line_burst_mem.sv
// -----------------------------------------------------------------------------
// line_burst_mem
// Line-granular backing memory for the data cache. Each accepted line request
// runs LATENCY wait cycles, then a word-serial burst of LINE_SIZE words, then
// a one-cycle gnt. Writes win over reads when both are requested.
//   clk  clock
//   rst  asynchronous active-high reset (storage is not touched)
//   bus  line_burst_mem_if slave port (gnt, addr, rd_req, wr_req,
//        rd_line, wr_line)
// -----------------------------------------------------------------------------
module line_burst_mem
    import mem_pkg::*;
#(
    parameter int LINE_ADDR_LEN = 3,
    parameter int ADDR_LEN      = 9,
    parameter int LATENCY       = 4
) (
    input  logic             clk,
    input  logic             rst,
    line_burst_mem_if.slave  bus
);

    localparam int LS    = line_size(LINE_ADDR_LEN);
    localparam int WAW   = ADDR_LEN + LINE_ADDR_LEN;
    localparam int LAT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

    state_t                       state, state_n;
    op_t                          op_q;
    logic [ADDR_LEN-1:0]          addr_q;
    logic [LS-1:0][WORD_W-1:0]    wr_line_q;
    logic [LS-1:0][WORD_W-1:0]    rd_line_q;
    logic [LINE_ADDR_LEN-1:0]     beat;
    logic [LAT_W-1:0]             lat_cnt;
    logic                         req;
    logic                         gnt;
    logic                         ram_we;
    logic [WAW-1:0]               ram_addr;
    logic [WORD_W-1:0]            ram_rdata;

    assign req = bus.wr_req | bus.rd_req;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_n = state;
        gnt     = 1'b0;
        ram_we  = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    state_n = (LATENCY > 0) ? WAIT : BURST;
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_n = BURST;
                end
            end
            BURST: begin
                ram_we = (op_q == OP_WRITE);
                if (beat == '1) begin
                    state_n = DONE;
                end
            end
            DONE: begin
                gnt     = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request latch, counters and the read-line register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_READ;
            addr_q    <= '0;
            wr_line_q <= '0;
            rd_line_q <= '0;
            beat      <= '0;
            lat_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        op_q    <= bus.wr_req ? OP_WRITE : OP_READ;
                        addr_q  <= bus.addr;
                        lat_cnt <= '0;
                        beat    <= '0;
                        if (bus.wr_req) begin
                            wr_line_q <= bus.wr_line;
                        end
                    end
                end
                WAIT: begin
                    lat_cnt <= lat_cnt + 1'b1;
                end
                BURST: begin
                    if (op_q == OP_READ) begin
                        rd_line_q[beat] <= ram_rdata;
                    end
                    // Wraps to zero on the last beat; never carries into addr_q.
                    beat <= beat + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ram_addr = {addr_q, beat};

    mem_word_ram #(
        .AW (WAW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wr_line_q[beat]),
        .rdata (ram_rdata)
    );

    assign bus.gnt     = gnt;
    assign bus.rd_line = rd_line_q;

endmodule

// File: tb/tb_line_burst_mem.sv
// -----------------------------------------------------------------------------
// tb_line_burst_mem
// Self-checking bench for line_burst_mem: a LATENCY=4 instance for the main
// sequences and a LATENCY=0 instance for the zero-latency build. Expected
// grant latency and read line are queued when a request is driven and
// compared when gnt arrives.
// -----------------------------------------------------------------------------
module tb_line_burst_mem;
    import mem_pkg::*;

    localparam int LAL = 3;
    localparam int AL  = 9;
    localparam int LS  = 8;
    localparam int LAT = 4;

    typedef logic [LS-1:0][31:0] line_t;

    typedef struct {
        bit wr;
        int addr;
        int wbase;
        int rbase;
        bit chain;
        bit scramble;
    } vec_t;

    typedef struct {
        line_t rd_line;
        int    cycles;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    exp_t  sb[$];
    line_t last_rd[2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    line_burst_mem_if #(.ADDR_LEN(AL), .LINE_SIZE(LS)) bus0 ();
    line_burst_mem_if #(.ADDR_LEN(AL), .LINE_SIZE(LS)) bus1 ();

    line_burst_mem #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .LATENCY(LAT)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    line_burst_mem #(.LINE_ADDR_LEN(LAL), .ADDR_LEN(AL), .LATENCY(0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic line_t mk_line(input int base);
        line_t l;
        for (int k = 0; k < LS; k++) begin
            l[k] = 32'(base + k);
        end
        return l;
    endfunction

    function automatic logic gnt_of(input int sel);
        return (sel == 0) ? bus0.gnt : bus1.gnt;
    endfunction

    function automatic line_t rdline_of(input int sel);
        return (sel == 0) ? bus0.rd_line : bus1.rd_line;
    endfunction

    task automatic drive(input int sel, input bit wr, input bit rd, input int addr, input line_t wl);
        if (sel == 0) begin
            bus0.wr_req  = wr;
            bus0.rd_req  = rd;
            bus0.addr    = AL'(addr);
            bus0.wr_line = wl;
        end else begin
            bus1.wr_req  = wr;
            bus1.rd_req  = rd;
            bus1.addr    = AL'(addr);
            bus1.wr_line = wl;
        end
    endtask

    task automatic drop(input int sel, input bit drop_wr, input bit drop_rd);
        if (sel == 0) begin
            if (drop_wr) bus0.wr_req = 1'b0;
            if (drop_rd) bus0.rd_req = 1'b0;
        end else begin
            if (drop_wr) bus1.wr_req = 1'b0;
            if (drop_rd) bus1.rd_req = 1'b0;
        end
    endtask

    // Waits (bounded) for gnt, compares against the scoreboard head, then
    // drops the selected requests just after the edge that ends DONE.
    task automatic wait_gnt(input int sel, input string name, input bit drop_wr,
                            input bit drop_rd, input bit scramble, output int gcyc);
        int   n = 0;
        bit   seen = 1'b0;
        exp_t e;
        while (n < 40) begin
            @(negedge clk);
            if (scramble && n == 2) begin
                // Late changes to addr/wr_line must not affect the operation.
                if (sel == 0) begin
                    bus0.addr    = ~bus0.addr;
                    bus0.wr_line = ~bus0.wr_line;
                end else begin
                    bus1.addr    = ~bus1.addr;
                    bus1.wr_line = ~bus1.wr_line;
                end
            end
            if (gnt_of(sel)) begin
                seen = 1'b1;
                break;
            end
            n++;
        end
        gcyc = cyc;
        check({name, " gnt seen"}, 256'(seen), 256'(1));
        if (sb.size() == 0) begin
            check({name, " scoreboard entry"}, 256'(0), 256'(1));
        end else begin
            e = sb.pop_front();
            if (seen) begin
                check({name, " latency"}, 256'(n), 256'(e.cycles));
                check({name, " rd_line"}, 256'(rdline_of(sel)), 256'(e.rd_line));
            end
        end
        @(posedge clk);
        #1;
        drop(sel, drop_wr, drop_rd);
    endtask

    task automatic idle_check(input int sel, input string name, input int n);
        bit bad = 1'b0;
        repeat (n) begin
            @(negedge clk);
            if (gnt_of(sel) !== 1'b0) bad = 1'b1;
        end
        check(name, 256'(bad), 256'(0));
    endtask

    task automatic push_exp(input int sel, input bit is_rd, input line_t rl, input int cycles);
        exp_t e;
        if (is_rd) begin
            last_rd[sel] = rl;
        end
        e.rd_line = last_rd[sel];
        e.cycles  = cycles;
        sb.push_back(e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t  vecs[7];
        int    g;
        int    g_prev;
        line_t l;
        int    lat_cycles;

        lat_cycles = LAT + LS + 1;
        last_rd[0] = '0;
        last_rd[1] = '0;

        rst = 1'b1;
        drive(0, 0, 0, 0, '0);
        drive(1, 0, 0, 0, '0);
        repeat (3) @(negedge clk);
        check("reset gnt", 256'(bus0.gnt), 256'(0));
        check("reset rd_line", 256'(bus0.rd_line), 256'(0));
        check("reset state", 256'(dut0.state), 256'(IDLE));
        check("reset gnt lat0", 256'(bus1.gnt), 256'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // {wr, addr, wbase, rbase, chain, scramble}
        vecs = '{
            '{1'b0, 5, 0,       40,      1'b0, 1'b0},
            '{1'b1, 5, 'hA000,  0,       1'b0, 1'b1},
            '{1'b0, 5, 0,       'hA000,  1'b0, 1'b0},
            '{1'b0, 4, 0,       32,      1'b0, 1'b0},
            '{1'b1, 2, 'hB000,  0,       1'b0, 1'b0},
            '{1'b0, 9, 0,       72,      1'b1, 1'b0},
            '{1'b0, 2, 0,       'hB000,  1'b0, 1'b0}
        };

        g_prev = 0;
        for (int i = 0; i < 7; i++) begin
            if (i > 0 && !vecs[i].chain) begin
                idle_check(0, $sformatf("vec%0d idle gap", i), 2);
                @(posedge clk);
                #1;
            end
            push_exp(0, !vecs[i].wr, mk_line(vecs[i].rbase), lat_cycles);
            drive(0, vecs[i].wr, !vecs[i].wr, vecs[i].addr, mk_line(vecs[i].wbase));
            wait_gnt(0, $sformatf("vec%0d", i), 1'b1, 1'b1, vecs[i].scramble, g);
            if (vecs[i].chain) begin
                check($sformatf("vec%0d gnt spacing", i), 256'(g - g_prev), 256'(lat_cycles + 1));
            end
            g_prev = g;
        end

        // Simultaneous write and read: write first, read accepted right after.
        idle_check(0, "both idle gap", 2);
        @(posedge clk);
        #1;
        push_exp(0, 1'b0, '0, lat_cycles);
        push_exp(0, 1'b1, mk_line('hD000), lat_cycles);
        drive(0, 1, 1, 1, mk_line('hD000));
        wait_gnt(0, "both write", 1'b1, 1'b0, 1'b0, g_prev);
        wait_gnt(0, "both read", 1'b1, 1'b1, 1'b0, g);
        check("both gnt spacing", 256'(g - g_prev), 256'(lat_cycles + 1));

        // Reset in the middle of a write burst to line 3, at beat 4.
        idle_check(0, "abort idle gap", 2);
        @(posedge clk);
        #1;
        drive(0, 1, 0, 3, mk_line('hC000));
        repeat (LAT + 6) @(negedge clk);
        check("abort in burst", 256'(dut0.state), 256'(BURST));
        check("abort beat", 256'(dut0.beat), 256'(4));
        rst = 1'b1;
        drive(0, 0, 0, 0, '0);
        #1;
        check("abort state", 256'(dut0.state), 256'(IDLE));
        check("abort rd_line", 256'(bus0.rd_line), 256'(0));
        check("abort gnt", 256'(bus0.gnt), 256'(0));
        last_rd[0] = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_check(0, "abort no gnt", 20);
        @(posedge clk);
        #1;
        l = mk_line(24);
        for (int k = 0; k < 4; k++) begin
            l[k] = 32'('hC000 + k);
        end
        push_exp(0, 1'b1, l, lat_cycles);
        drive(0, 0, 1, 3, '0);
        wait_gnt(0, "abort readback", 1'b1, 1'b1, 1'b0, g);
        idle_check(0, "abort readback idle", 3);

        // Zero-latency build.
        @(posedge clk);
        #1;
        push_exp(1, 1'b1, mk_line(0), LS + 1);
        drive(1, 0, 1, 0, '0);
        wait_gnt(1, "lat0 read", 1'b1, 1'b1, 1'b0, g);
        idle_check(1, "lat0 idle", 3);

        check("scoreboard drained", 256'(sb.size()), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
